serial_sub: RTL

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_pkg.sv | 22 ++
 rtl/fa.sv | 16 +
 rtl/serial_sub.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared constants for the bit-serial subtractor: default operand width,
// FSM state encoding and the bit-counter sizing rule.
package serial_pkg;

    // Operand/difference width used when the instantiating code does not override it.
    localparam int DEFAULT_WIDTH = 4;

    // Controller states; the encoding is fixed so other blocks and debug
    // tooling can decode a captured state vector.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width. The extra bit keeps the counter from wrapping when
    // it is incremented past WIDTH-1 on the final RUN cycle.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/fa.sv
// One-bit full adder: s = a ^ b ^ ci, co = majority(a, b, ci).
module fa (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic ci
);

    // Sum and carry are pure combinational functions of the three inputs.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: d = a - b - bi (mod 2^WIDTH), bo = borrow out.
// One bit is processed per cycle, LSB first, as a + ~b + c, where the carry
// register c holds the inverted borrow. A start accepted in IDLE spends
// WIDTH cycles in RUN and one cycle in DONE, where done pulses with d/bo valid.
module serial_sub
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 difference bits already produced; the last sum bit
    // joins them directly when d is loaded on entry to DONE.
    logic [WIDTH-2:0] res;
    logic [WIDTH-1:0] res_full;
    logic             c;
    logic [CW-1:0]    cnt;

    logic             load;
    logic             step;
    logic             finish;
    logic             last_bit;

    logic             b_inv;
    logic             sum;
    logic             cout;

    // Subtraction as addition of the one's complement: the adder sees ~b.
    assign b_inv    = ~b_sr[0];
    assign res_full = {sum, res};
    assign last_bit = (cnt == CW'(WIDTH - 1));

    fa u_fa (
        .s  (sum),
        .co (cout),
        .a  (a_sr[0]),
        .b  (b_inv),
        .ci (c)
    );

    // State register; reset forces IDLE and aborts any operation in flight.
    always_ff @(posedge clk) begin
        // NOTE: every clocked block uses non-blocking assignments so all
        // registers sample the same pre-edge values, independent of block order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control strobes for the datapath.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last_bit) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand/result shift registers, carry and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            res  <= '0;
            c    <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            a_sr <= a;
            b_sr <= b;
            res  <= '0;
            c    <= ~bi;
            cnt  <= '0;
        end else if (step) begin
            a_sr <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr <= {1'b0, b_sr[WIDTH-1:1]};
            res  <= res_full[WIDTH-1:1];
            c    <= cout;
            cnt  <= cnt + CW'(1);
        end
    end

    // Registered outputs: d/bo load only when entering DONE and hold otherwise;
    // busy mirrors the state being entered, done pulses for the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            d    <= '0;
            bo   <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= finish;
            if (finish) begin
                d  <= res_full;
                bo <= ~cout;
            end
        end
    end

endmodule
